// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack -- parameterised LIFO stack with a combinational top-of-stack
// read port.
//
// Optional feature: define STACK_ERR_EN to build the sticky error flags
// (err_clr, ovf, udf). Without it those ports and their logic are absent.
//
// Parameters
//   WIDTH : data word width in bits (>=1)
//   DEPTH : maximum number of stored entries (>=2)
//   CW    : occupancy count width
//
// Ports
//   clk     : clock, rising-edge active
//   rst     : synchronous active-high reset (clears count and flags only)
//   push    : push request; together with pop it replaces the top entry
//   pop     : pop request
//   d_in    : word to push / replace with
//   err_clr : clear sticky error flags                 (STACK_ERR_EN only)
//   ovf     : sticky push-while-full flag              (STACK_ERR_EN only)
//   udf     : sticky pop-while-empty flag              (STACK_ERR_EN only)
//   d_out   : current top-of-stack word, zero when empty
//   tos     : current occupancy count
//   full    : tos == DEPTH
//   empty   : tos == 0
// ---------------------------------------------------------------------------
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d_in,
`ifdef STACK_ERR_EN
  input  logic             err_clr,
  output logic             ovf,
  output logic             udf,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic [CW-1:0]    tos,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    tos_q, tos_d;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign full    = (tos_q == CW'(DEPTH));
  assign empty   = (tos_q == '0);
  assign tos     = tos_q;
  assign rd_addr = AW'(tos_q - CW'(1));

  // Top of stack; stale memory left behind by reset stays hidden when empty.
  always_comb begin
    d_out = '0;
    if (!empty) d_out = mem_q[rd_addr];
  end

  // Push+pop on an empty stack degenerates to a plain push; on a non-empty
  // stack it overwrites the top entry in place, even when full.
  always_comb begin
    tos_d   = tos_q;
    we      = 1'b0;
    wr_addr = '0;
    if (push && (!pop || empty)) begin
      if (!full) begin
        we      = 1'b1;
        wr_addr = AW'(tos_q);
        tos_d   = tos_q + CW'(1);
      end
    end else if (push && pop) begin
      we      = 1'b1;
      wr_addr = rd_addr;
    end else if (pop && !empty) begin
      tos_d = tos_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tos_q <= '0;
    else     tos_q <= tos_d;
  end

  // Storage is deliberately not reset; only the write is blocked during reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wr_addr] <= d_in;
  end

`ifdef STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = (push && !pop && full)  || (ovf_q && !err_clr);
    udf_d = (pop && !push && empty) || (udf_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    tos;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .d_in   (d_in),
`ifdef STACK_ERR_EN
    .err_clr(err_clr),
    .ovf    (ovf),
    .udf    (udf),
`endif
    .d_out  (d_out),
    .tos    (tos),
    .full   (full),
    .empty  (empty)
  );

`ifndef STACK_ERR_EN
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  // Reference model: a queue whose last element is the top of stack.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  task automatic model_update();
    bit set_o, set_u;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      set_o = push && !pop && (mq.size() == DEPTH);
      set_u = pop && !push && (mq.size() == 0);
      if (push && (!pop || mq.size() == 0)) begin
        if (mq.size() < DEPTH) mq.push_back(d_in);
      end else if (push && pop) begin
        mq[mq.size()-1] = d_in;
      end else if (pop && mq.size() > 0) begin
        void'(mq.pop_back());
      end
      m_ovf = set_o || (m_ovf && !err_clr);
      m_udf = set_u || (m_udf && !err_clr);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic po,
                      input logic c, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r; push = p; pop = po; err_clr = c; d_in = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic             r, p, po, c;
    logic [WIDTH-1:0] d;
    int               e_tos;
    logic [WIDTH-1:0] e_dout;
    logic             e_full, e_empty, e_ovf, e_udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic p, logic po, logic c, logic [WIDTH-1:0] d,
                              int t, logic [WIDTH-1:0] q, logic f, logic e, logic o, logic u);
    vec_t v;
    v.r = r; v.p = p; v.po = po; v.c = c; v.d = d;
    v.e_tos = t; v.e_dout = q; v.e_full = f; v.e_empty = e; v.e_ovf = o; v.e_udf = u;
    return v;
  endfunction

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; d_in = '0;

    //               rst  push pop  clr  d_in   tos dout  full empty ovf udf
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0)); // reset
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h11, 1, 8'h11, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h22, 2, 8'h22, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h33, 3, 8'h33, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h44, 4, 8'h44, 1'b1,1'b0,1'b0,1'b0)); // full
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h55, 4, 8'h44, 1'b1,1'b0,1'b1,1'b0)); // overflow
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 4, 8'h44, 1'b1,1'b0,1'b0,1'b0)); // clear
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 3, 8'h33, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 2, 8'h22, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1, 8'h11, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0)); // empty
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b1)); // underflow
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b1)); // set beats clear
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h11, 1, 8'h11, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h22, 2, 8'h22, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,8'h99, 2, 8'h99, 1'b0,1'b0,1'b0,1'b0)); // replace top
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1, 8'h11, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,8'h77, 1, 8'h77, 1'b0,1'b0,1'b0,1'b0)); // push+pop empty
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h01, 2, 8'h01, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h02, 3, 8'h02, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,8'h55, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0)); // reset beats push
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'hAB, 1, 8'hAB, 1'b0,1'b0,1'b0,1'b0)); // lands at index 0
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'hC1, 2, 8'hC1, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'hC2, 3, 8'hC2, 1'b0,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'hC3, 4, 8'hC3, 1'b1,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,8'h5A, 4, 8'h5A, 1'b1,1'b0,1'b0,1'b0)); // replace when full
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,8'h66, 4, 8'h5A, 1'b1,1'b0,1'b1,1'b0)); // ovf set beats clear
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00, 0, 8'h00, 1'b0,1'b1,1'b0,1'b0)); // reset clears flags

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].p, tbl[i].po, tbl[i].c, tbl[i].d);
      check($sformatf("vec%0d tos", i),   32'(tos),   32'(tbl[i].e_tos));
      check($sformatf("vec%0d d_out", i), 32'(d_out), 32'(tbl[i].e_dout));
      check($sformatf("vec%0d full", i),  32'(full),  32'(tbl[i].e_full));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
`ifdef STACK_ERR_EN
      check($sformatf("vec%0d ovf", i),   32'(ovf),   32'(tbl[i].e_ovf));
      check($sformatf("vec%0d udf", i),   32'(udf),   32'(tbl[i].e_udf));
`endif
    end

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      logic r, p, po, c;
      logic [WIDTH-1:0] d;
      r  = ($urandom_range(0, 99) == 0);
      p  = $urandom_range(0, 1) == 1;
      po = $urandom_range(0, 1) == 1;
      c  = ($urandom_range(0, 7) == 0);
      d  = WIDTH'($urandom);
      step(r, p, po, c, d);
      check("rnd tos",   32'(tos),   32'(mq.size()));
      check("rnd d_out", 32'(d_out), (mq.size() > 0) ? 32'(mq[mq.size()-1]) : 32'd0);
      check("rnd full",  32'(full),  32'(mq.size() == DEPTH));
      check("rnd empty", 32'(empty), 32'(mq.size() == 0));
`ifdef STACK_ERR_EN
      check("rnd ovf",   32'(ovf),   32'(m_ovf));
      check("rnd udf",   32'(udf),   32'(m_udf));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
